// File: rtl/chip8_pkg.sv
// ---------------------------------------------------------------------------
// chip8_pkg
// Shared constants and types for the CHIP-8 display path.
//   FB_BASE          byte address of framebuffer row 0, byte 0
//   SCREEN_W/H       display size in pixels (64 x 32, 1 bpp)
//   FB_BYTES_PER_ROW bytes per framebuffer row, MSB is the leftmost pixel
//   blit_state_e     states of the sprite blitter sequencer
// ---------------------------------------------------------------------------
package chip8_pkg;

  localparam logic [11:0] FB_BASE          = 12'hF00;
  localparam int          SCREEN_W         = 64;
  localparam int          SCREEN_H         = 32;
  localparam int          FB_BYTES_PER_ROW = 8;

  typedef enum logic [3:0] {
    IDLE,
    SPR_RD,
    SPR_WAIT,
    L_RD,
    L_WAIT,
    L_WR,
    R_RD,
    R_WAIT,
    R_WR,
    CLR,
    DONE
  } blit_state_e;

endpackage

// File: rtl/sprite_blitter.sv
// ---------------------------------------------------------------------------
// sprite_blitter
// Executes CHIP-8 DXYN (XOR sprite draw) and 00E0 (screen clear) against the
// framebuffer in system memory, through the memory block's GPU port.
//
// Ports
//   clk, reset            system clock, asynchronous active-high reset
//   draw, clear           start requests, sampled only in IDLE; clear wins
//   sprite_addr, x, y     I register, Vx, Vy (x used mod 64, y used mod 32)
//   rows                  sprite height N (0..15)
//   busy                  high whenever not IDLE
//   done                  one-cycle pulse at the end of an operation
//   collision             VF result, valid in the done cycle, held until the
//                         next start
//   gpu_read*             one-cycle read request, address, data + ack
//   gpu_write*            one-cycle write strobe, address, data
// ---------------------------------------------------------------------------
module sprite_blitter
  import chip8_pkg::*;
#(
  parameter logic [11:0] FB_BASE_ADDR = FB_BASE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        draw,
  input  logic        clear,
  input  logic [11:0] sprite_addr,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  input  logic [3:0]  rows,
  output logic        busy,
  output logic        done,
  output logic        collision,
  output logic        gpu_read,
  output logic [11:0] gpu_read_addr,
  input  logic [7:0]  gpu_read_data,
  input  logic        gpu_read_ack,
  output logic        gpu_write,
  output logic [11:0] gpu_write_addr,
  output logic [7:0]  gpu_write_data
);

  localparam int XW = $clog2(SCREEN_W);
  localparam int YW = $clog2(SCREEN_H);
  localparam int BW = $clog2(FB_BYTES_PER_ROW);

  blit_state_e   state_q, state_d;
  logic [11:0]   sprBase_q;
  logic [XW-BW-1:0] xShift_q;
  logic [BW-1:0] xByte_q;
  logic [YW-1:0] yRow_q;
  logic [3:0]    rows_q;
  logic [3:0]    rowCnt_q;
  logic [7:0]    clrCnt_q;
  logic [7:0]    spr_q;
  logic [7:0]    fb_q;
  logic          collision_q;

  logic [YW-1:0] fbRow;
  logic [BW-1:0] xByteR;
  logic [11:0]   leftAddr;
  logic [11:0]   rightAddr;
  logic [7:0]    maskL;
  logic [7:0]    maskR;
  logic          lastRow;
  logic          rightNeeded;
  logic          unusedBits;

  // The modulo wrap discards the upper bits of x and y.
  assign unusedBits = ^{x[7:XW], y[7:YW]};

  // Per-row geometry. Row index and byte column wrap naturally through the
  // field widths, which gives vertical and horizontal wraparound for free.
  always_comb begin
    fbRow       = yRow_q + YW'(rowCnt_q);
    xByteR      = xByte_q + BW'(1);
    leftAddr    = FB_BASE_ADDR + 12'({fbRow, xByte_q});
    rightAddr   = FB_BASE_ADDR + 12'({fbRow, xByteR});
    maskL       = spr_q >> xShift_q;
    maskR       = spr_q << (4'd8 - {1'b0, xShift_q});
    lastRow     = (rowCnt_q == rows_q - 4'd1);
    rightNeeded = (xShift_q != '0);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. WAIT states hold until the memory acknowledges.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d = CLR;
        end else if (draw) begin
          state_d = (rows == 4'd0) ? DONE : SPR_RD;
        end
      end
      SPR_RD:   state_d = SPR_WAIT;
      SPR_WAIT: if (gpu_read_ack) state_d = L_RD;
      L_RD:     state_d = L_WAIT;
      L_WAIT:   if (gpu_read_ack) state_d = L_WR;
      L_WR: begin
        if (rightNeeded) begin
          state_d = R_RD;
        end else begin
          state_d = lastRow ? DONE : SPR_RD;
        end
      end
      R_RD:     state_d = R_WAIT;
      R_WAIT:   if (gpu_read_ack) state_d = R_WR;
      R_WR:     state_d = lastRow ? DONE : SPR_RD;
      CLR:      if (clrCnt_q == 8'hFF) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs decoded from the current state. Read addresses stay on the bus
  // through the matching WAIT state; the strobe is single-cycle.
  always_comb begin
    busy           = (state_q != IDLE);
    done           = (state_q == DONE);
    gpu_read       = 1'b0;
    gpu_read_addr  = '0;
    gpu_write      = 1'b0;
    gpu_write_addr = '0;
    gpu_write_data = '0;
    case (state_q)
      SPR_RD, SPR_WAIT: begin
        gpu_read      = (state_q == SPR_RD);
        gpu_read_addr = sprBase_q + 12'(rowCnt_q);
      end
      L_RD, L_WAIT: begin
        gpu_read      = (state_q == L_RD);
        gpu_read_addr = leftAddr;
      end
      L_WR: begin
        gpu_write      = 1'b1;
        gpu_write_addr = leftAddr;
        gpu_write_data = fb_q ^ maskL;
      end
      R_RD, R_WAIT: begin
        gpu_read      = (state_q == R_RD);
        gpu_read_addr = rightAddr;
      end
      R_WR: begin
        gpu_write      = 1'b1;
        gpu_write_addr = rightAddr;
        gpu_write_data = fb_q ^ maskR;
      end
      CLR: begin
        gpu_write      = 1'b1;
        gpu_write_addr = FB_BASE_ADDR + 12'(clrCnt_q);
        gpu_write_data = 8'h00;
      end
      default: ;
    endcase
  end

  assign collision = collision_q;

  // Datapath: operand latch on start, sprite/framebuffer capture on ack,
  // collision accumulation and counter advance on each write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sprBase_q   <= '0;
      xShift_q    <= '0;
      xByte_q     <= '0;
      yRow_q      <= '0;
      rows_q      <= '0;
      rowCnt_q    <= '0;
      clrCnt_q    <= '0;
      spr_q       <= '0;
      fb_q        <= '0;
      collision_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clear || draw) begin
            sprBase_q   <= sprite_addr;
            xShift_q    <= x[XW-BW-1:0];
            xByte_q     <= x[XW-1:XW-BW];
            yRow_q      <= y[YW-1:0];
            rows_q      <= rows;
            rowCnt_q    <= '0;
            clrCnt_q    <= '0;
            collision_q <= 1'b0;
          end
        end
        SPR_WAIT: if (gpu_read_ack) spr_q <= gpu_read_data;
        L_WAIT, R_WAIT: if (gpu_read_ack) fb_q <= gpu_read_data;
        L_WR: begin
          collision_q <= collision_q | (|(fb_q & maskL));
          if (!rightNeeded) rowCnt_q <= rowCnt_q + 4'd1;
        end
        R_WR: begin
          collision_q <= collision_q | (|(fb_q & maskR));
          rowCnt_q    <= rowCnt_q + 4'd1;
        end
        CLR: clrCnt_q <= clrCnt_q + 8'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// ---------------------------------------------------------------------------
// tb_sprite_blitter
// Drives sprite_blitter against a behavioural GPU-port memory with
// programmable ack latency. Expected framebuffer contents and collision come
// from a pixel-level model of the draw/clear rules; expected write order,
// latency and read counts are derived from those rules as well.
// ---------------------------------------------------------------------------
module tb_sprite_blitter;
  import chip8_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        draw;
  logic        clear;
  logic [11:0] spriteAddr;
  logic [7:0]  xIn;
  logic [7:0]  yIn;
  logic [3:0]  rowsIn;
  logic        busy;
  logic        done;
  logic        collision;
  logic        gpuRead;
  logic [11:0] gpuReadAddr;
  logic [7:0]  gpuReadData = 8'h00;
  logic        gpuReadAck = 1'b0;
  logic        gpuWrite;
  logic [11:0] gpuWriteAddr;
  logic [7:0]  gpuWriteData;

  always #5 clk = ~clk;

  sprite_blitter dut (
    .clk            (clk),
    .reset          (reset),
    .draw           (draw),
    .clear          (clear),
    .sprite_addr    (spriteAddr),
    .x              (xIn),
    .y              (yIn),
    .rows           (rowsIn),
    .busy           (busy),
    .done           (done),
    .collision      (collision),
    .gpu_read       (gpuRead),
    .gpu_read_addr  (gpuReadAddr),
    .gpu_read_data  (gpuReadData),
    .gpu_read_ack   (gpuReadAck),
    .gpu_write      (gpuWrite),
    .gpu_write_addr (gpuWriteAddr),
    .gpu_write_data (gpuWriteData)
  );

  typedef struct packed {
    logic [11:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic [7:0] mem [0:4095];
  logic [7:0] modelFb [0:255];
  wr_t        expWrites [$];
  int         compared = 0;
  int         mismatched = 0;
  int         ackMin = 0;
  int         ackMax = 0;
  int         extraTotal = 0;
  int         readTotal = 0;
  bit         pending = 1'b0;
  int         waitLeft = 0;
  logic [11:0] pendAddr = '0;

  // Memory behind the GPU port: writes land at mid-cycle of the strobe,
  // reads are acknowledged one cycle after the request plus a chosen delay.
  always @(negedge clk) begin
    if (reset) begin
      pending    = 1'b0;
      gpuReadAck = 1'b0;
    end else begin
      gpuReadAck = 1'b0;
      if (gpuWrite) mem[gpuWriteAddr] = gpuWriteData;
      if (pending) begin
        if (waitLeft == 0) begin
          gpuReadAck  = 1'b1;
          gpuReadData = mem[pendAddr];
          pending     = 1'b0;
        end else begin
          waitLeft = waitLeft - 1;
        end
      end
      if (gpuRead) begin
        pending    = 1'b1;
        pendAddr   = gpuReadAddr;
        waitLeft   = int'($urandom_range(ackMax, ackMin));
        extraTotal = extraTotal + waitLeft;
        readTotal  = readTotal + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Runs one operation; builds the model expectation first, then checks the
  // DUT every cycle until done (bounded).
  task automatic applyStimulus(input bit doClear, input bit doDraw,
                               input logic [11:0] a, input logic [7:0] vx,
                               input logic [7:0] vy, input logic [3:0] n,
                               output int doneCyc);
    int expCyc, expReads, cyc, extraStart, readStart;
    int ix, iy, nn, px, py, idx, bad;
    bit expColl, seen;
    logic [7:0] spr;
    wr_t w;
    expWrites.delete();
    expColl = 1'b0;
    ix = int'(vx) % SCREEN_W;
    iy = int'(vy) % SCREEN_H;
    nn = int'(n);
    if (doClear) begin
      for (int i = 0; i < 256; i++) begin
        modelFb[i] = 8'h00;
        w.addr = FB_BASE + 12'(i);
        w.data = 8'h00;
        expWrites.push_back(w);
      end
      expCyc   = 257;
      expReads = 0;
    end else begin
      for (int r = 0; r < nn; r++) begin
        spr = mem[(int'(a) + r) % 4096];
        for (int c = 0; c < 8; c++) begin
          if (spr[7 - c]) begin
            px  = (ix + c) % SCREEN_W;
            py  = (iy + r) % SCREEN_H;
            idx = py * FB_BYTES_PER_ROW + px / 8;
            if (modelFb[idx][7 - (px % 8)]) expColl = 1'b1;
            modelFb[idx][7 - (px % 8)] = ~modelFb[idx][7 - (px % 8)];
          end
        end
      end
      for (int r = 0; r < nn; r++) begin
        py     = (iy + r) % SCREEN_H;
        idx    = py * FB_BYTES_PER_ROW + ix / 8;
        w.addr = FB_BASE + 12'(idx);
        w.data = modelFb[idx];
        expWrites.push_back(w);
        if (ix % 8 != 0) begin
          idx    = py * FB_BYTES_PER_ROW + ((ix / 8 + 1) % 8);
          w.addr = FB_BASE + 12'(idx);
          w.data = modelFb[idx];
          expWrites.push_back(w);
        end
      end
      expCyc   = 1 + nn * ((ix % 8 != 0) ? 8 : 5);
      expReads = nn * ((ix % 8 != 0) ? 3 : 2);
    end
    extraStart = extraTotal;
    readStart  = readTotal;
    @(negedge clk); #1;
    spriteAddr = a;
    xIn        = vx;
    yIn        = vy;
    rowsIn     = n;
    clear      = doClear;
    draw       = doDraw;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 6000) begin
      @(negedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        draw  = 1'b0;
        clear = 1'b0;
      end
      checkOutput("busy", busy, 1);
      checkOutput("rd_wr_exclusive", gpuRead & gpuWrite, 0);
      if (gpuWrite) begin
        if (expWrites.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_write: got addr %0h data %0h, expected none",
                   gpuWriteAddr, gpuWriteData);
        end else begin
          w = expWrites.pop_front();
          checkOutput("write_addr", gpuWriteAddr, w.addr);
          checkOutput("write_data", gpuWriteData, w.data);
        end
      end
      if (done) seen = 1'b1;
    end
    checkOutput("done_seen", seen, 1);
    checkOutput("done_cycle", cyc, expCyc + (extraTotal - extraStart));
    checkOutput("collision", collision, expColl);
    checkOutput("writes_missing", expWrites.size(), 0);
    checkOutput("read_count", readTotal - readStart, expReads);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (mem[FB_BASE + 12'(i)] !== modelFb[i]) bad++;
    end
    checkOutput("fb_bytes_wrong", bad, 0);
    doneCyc = cyc;
  endtask

  initial begin
    int dc;
    logic [11:0] ra;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    for (int i = 0; i < 256; i++) modelFb[i] = 8'h00;
    mem[12'h014] = 8'hF0; mem[12'h015] = 8'h90; mem[12'h016] = 8'h90;
    mem[12'h017] = 8'h90; mem[12'h018] = 8'hF0;
    mem[12'h100] = 8'hFF; mem[12'h101] = 8'h81;
    reset = 1'b1; draw = 1'b0; clear = 1'b0;
    spriteAddr = '0; xIn = '0; yIn = '0; rowsIn = '0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_collision", collision, 0);
    checkOutput("rst_gpu_read", gpuRead, 0);
    checkOutput("rst_gpu_write", gpuWrite, 0);
    checkOutput("rst_read_addr", gpuReadAddr, 0);
    checkOutput("rst_write_addr", gpuWriteAddr, 0);
    checkOutput("rst_write_data", gpuWriteData, 0);
    reset = 1'b0;

    $display("[TB] font draw on empty framebuffer");
    applyStimulus(1'b0, 1'b1, 12'h014, 8'd0, 8'd0, 4'd5, dc);
    checkOutput("font_done_cycle", dc, 26);
    checkOutput("font_collision", collision, 0);
    checkOutput("font_b0", mem[12'hF00], 8'hF0);
    checkOutput("font_b8", mem[12'hF08], 8'h90);
    checkOutput("font_b16", mem[12'hF10], 8'h90);
    checkOutput("font_b24", mem[12'hF18], 8'h90);
    checkOutput("font_b32", mem[12'hF20], 8'hF0);

    $display("[TB] font redraw erases");
    applyStimulus(1'b0, 1'b1, 12'h014, 8'd0, 8'd0, 4'd5, dc);
    checkOutput("redraw_collision", collision, 1);
    checkOutput("redraw_b0", mem[12'hF00], 8'h00);
    checkOutput("redraw_b32", mem[12'hF20], 8'h00);

    $display("[TB] wraparound draw x=62 y=31");
    applyStimulus(1'b0, 1'b1, 12'h100, 8'd62, 8'd31, 4'd2, dc);
    checkOutput("wrap_done_cycle", dc, 17);
    checkOutput("wrap_fff", mem[12'hFFF], 8'h03);
    checkOutput("wrap_ff8", mem[12'hFF8], 8'hFC);
    checkOutput("wrap_f07", mem[12'hF07], 8'h02);
    checkOutput("wrap_f00", mem[12'hF00], 8'h04);

    $display("[TB] clear and draw together on dirty framebuffer");
    applyStimulus(1'b1, 1'b1, 12'h014, 8'd0, 8'd0, 4'd5, dc);
    checkOutput("clear_done_cycle", dc, 257);
    checkOutput("clear_collision", collision, 0);
    checkOutput("clear_fff", mem[12'hFFF], 8'h00);

    $display("[TB] rows=0 draw");
    applyStimulus(1'b0, 1'b1, 12'h014, 8'd5, 8'd5, 4'd0, dc);
    checkOutput("rows0_done_cycle", dc, 1);

    $display("[TB] draw with 3 extra ack cycles per read");
    ackMin = 3; ackMax = 3;
    applyStimulus(1'b0, 1'b1, 12'h014, 8'd0, 8'd0, 4'd5, dc);
    checkOutput("slow_done_cycle", dc, 56);
    ackMin = 0; ackMax = 0;

    $display("[TB] reset during L_WAIT");
    @(negedge clk); #1;
    spriteAddr = 12'h014; xIn = 8'd0; yIn = 8'd0; rowsIn = 4'd5; draw = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); #1;
      if (i == 1) draw = 1'b0;
    end
    checkOutput("abort_busy_before", busy, 1);
    reset = 1'b1;
    @(negedge clk); #1;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_collision", collision, 0);
    checkOutput("abort_gpu_read", gpuRead, 0);
    checkOutput("abort_gpu_write", gpuWrite, 0);
    checkOutput("abort_read_addr", gpuReadAddr, 0);
    repeat (2) begin
      @(negedge clk); #1;
      checkOutput("abort_no_done", done, 0);
    end
    reset = 1'b0;
    applyStimulus(1'b0, 1'b1, 12'h014, 8'd0, 8'd0, 4'd5, dc);
    checkOutput("after_abort_collision", collision, 1);

    $display("[TB] randomized operations");
    ackMin = 0; ackMax = 2;
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(9, 0) == 0) begin
        applyStimulus(1'b1, 1'($urandom_range(1, 0)), 12'h000, 8'd0, 8'd0, 4'd0, dc);
      end else begin
        ra = 12'($urandom_range(12'hEF0, 0));
        for (int i = 0; i < 16; i++) mem[ra + 12'(i)] = 8'($urandom);
        applyStimulus(1'b0, 1'b1, ra, 8'($urandom), 8'($urandom),
                      4'($urandom_range(15, 0)), dc);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Executes CHIP-8 display operations (DXYN draw, 00E0 clear) against the framebuffer held in system memory at FB_BASE (64×32 pixels, 1 bpp, 8 bytes per row, MSB = leftmost pixel). The block sits on the memory block's GPU port (gpu_read/gpu_read_ack/gpu_write). It fetches sprite bytes, read-modify-writes framebuffer bytes with XOR, and reports pixel collision (VF) to the CPU sequencer.

## Interface
- FB_BASE, 12'hF00: byte address of framebuffer row 0, byte 0; occupies FB_BASE..FB_BASE+255.
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; forces IDLE.
- draw  in  1  start DXYN; sampled only in IDLE.
- clear  in  1  start screen clear; sampled only in IDLE; wins over draw.
- sprite_addr  in  12  I register; sprite row r is at sprite_addr+r, mod 4096.
- x  in  8  Vx; used mod 64.
- y  in  8  Vy; used mod 32.
- rows  in  4  N, sprite height 0..15.
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle pulse at end of draw or clear.
- collision  out  1  valid in the done cycle; holds until next start.
- gpu_read  out  1  one-cycle read request.
- gpu_read_addr  out  12  read address.
- gpu_read_data  in  8  read data, valid with ack.
- gpu_read_ack  in  1  read completion, nominally one cycle after request.
- gpu_write  out  1  one-cycle write strobe.
- gpu_write_addr  out  12  write address.
- gpu_write_data  out  8  write data.

## Operation
- Reset values: busy=0, done=0, collision=0, gpu_read=0, gpu_write=0, all address and data outputs 0, state IDLE.
- On start, latch sprite_addr, x mod 64, y mod 32, and rows. Clear collision. Ignore draw and clear while busy.
- States: IDLE, SPR_RD, SPR_WAIT, L_RD, L_WAIT, L_WR, R_RD, R_WAIT, R_WR, CLR, DONE.
- Per row r:
  - fb_row = (y+r) mod 32.
  - s = x[2:0].
  - bl = x[5:3].
  - br = (bl+1) mod 8, so pixels wrap horizontally.
  - Left byte address = FB_BASE + fb_row*8 + bl. Mask = spr >> s. New value = fb ^ mask.
  - Right byte (visited only if s≠0) uses address br. Mask = (spr << (8−s))[7:0].
  - collision |= |(fb & mask)| for each byte.
- Rows wrap vertically, mod 32. There is no clipping.
- Sprite byte 0x00 is still fully processed (read and write-back with an unchanged value).
- rows=0: IDLE → DONE directly, with no memory access.
- Clear: write 0x00 to FB_BASE+0 … FB_BASE+255 in ascending order, one per cycle. collision stays 0.
- Transitions:
  - SPR_RD→SPR_WAIT
  - SPR_WAIT→L_RD on ack
  - L_RD→L_WAIT
  - L_WAIT→L_WR on ack
  - L_WR→R_RD if s≠0
  - L_WR→SPR_RD if more rows remain
  - L_WR→DONE otherwise
  - The R_* states mirror the L_* states.
  - CLR→DONE after address 255.
  - DONE→IDLE.
- WAIT states hold indefinitely until gpu_read_ack arrives. Data is captured in the ack cycle.
- Reset mid-operation aborts immediately. Partially written framebuffer bytes remain. No done pulse is issued.

## Timing
- Start sampled in cycle 0. busy is high from cycle 1 through the DONE cycle inclusive.
- Row cost with single-cycle ack: 5 cycles if s=0, 8 cycles if s≠0.
- done occurs at cycle 5N+1 (s=0) or 8N+1 (s≠0).
- Clear: writes in cycles 1..256, done at cycle 257.
- rows=0: done at cycle 1.
- Each extra ack-wait cycle adds one cycle of latency.
- gpu_read and gpu_write are never asserted in the same cycle.
- A write to address A issues at least one cycle after the read of A completes. This avoids a read-during-write hazard in memory.
- A new start is accepted in the cycle after DONE, i.e. in IDLE.

## Structure
- Shared package chip8_pkg holds:
  - FB_BASE default
  - SCREEN_W=64, SCREEN_H=32, FB_BYTES_PER_ROW=8
  - the blitter state enum
- Single module: FSM, a 4-bit row counter, an 8-bit clear counter, and a registered sprite byte.
- The address/mask computation is inline; no sub-module is needed.

## Test plan
- Draw font "0" (I=0x014, rows=5, x=0, y=0) on an empty framebuffer. Required: bytes F0,90,90,90,F0 at FB_BASE+0,8,16,24,32; collision=0; done at cycle 26.
- Repeat the same draw. Required: those bytes return to 00, collision=1.
- x=62, y=31, rows=2, sprite FF,81. Row 0 address: FB_BASE+255 (bl=7) gets 03 and FB_BASE+248 (br=0) gets FC. Row 1 wraps to y=0: FB_BASE+7 gets 02 and FB_BASE+0 gets 04. Required: done at cycle 17.
- Assert clear and draw together with a dirty framebuffer. Required: clear wins; 256 writes of 00; done at cycle 257; collision=0.
- rows=0. Required: done at cycle 1, no gpu_read/gpu_write. Then delay ack 3 cycles on a draw. Required: outputs held, latency +3 per read.
- Assert reset during L_WAIT. Required: all outputs 0 next cycle, no done; a following draw completes normally.
